// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared widths, refill state encoding and address helpers for the icache refill path
package icache_pkg;

  localparam int ADDR_W   = 32;
  localparam int LINE_W   = 512;
  localparam int BEAT_W   = 32;
  localparam int SETS     = 512;
  localparam int INDEX_W  = $clog2(SETS);
  localparam int OFFSET_W = $clog2(LINE_W / 8);
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
  localparam int BEATS    = LINE_W / BEAT_W;

  typedef enum logic [2:0] {
    ST_IDLE          = 3'd0,
    ST_REQUEST       = 3'd1,
    ST_COLLECT       = 3'd2,
    ST_WRITE         = 3'd3,
    ST_DONE          = 3'd4,
    ST_FLUSH         = 3'd5,
    ST_FLUSH_DONE_ST = 3'd6
  } refill_state_e;

  function automatic logic [INDEX_W-1:0] line_index(input logic [ADDR_W-1:0] addr);
    return addr[OFFSET_W +: INDEX_W];
  endfunction

  function automatic logic [TAG_W-1:0] line_tag(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/icache_line_assembler.sv
// rtl/icache_line_assembler.sv - beat counter and line buffer that packs narrow response beats into one cache line
module icache_line_assembler #(
  parameter int LINE_WIDTH = 512,
  parameter int BEAT_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  clear,
  input  logic                  insert,
  input  logic [BEAT_WIDTH-1:0] beat,
  output logic [LINE_WIDTH-1:0] line,
  output logic                  last
);

  localparam int BEATS = LINE_WIDTH / BEAT_WIDTH;
  localparam int CNT_W = $clog2(BEATS);

  logic [CNT_W-1:0] count;

  // Beat k always lands in slot k; the counter is reset on every miss accept.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      count <= '0;
      line  <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (insert) begin
      for (int i = 0; i < BEATS; i++) begin
        if (count == CNT_W'(i)) begin
          line[i*BEAT_WIDTH +: BEAT_WIDTH] <= beat;
        end
      end
      count <= count + 1'b1;
    end
  end

  assign last = (count == CNT_W'(BEATS - 1));

endmodule

// File: rtl/icache_line_refill.sv
// rtl/icache_line_refill.sv - icache miss refill engine: line request, beat collection, line/tag write and invalidate sweep
module icache_line_refill
  import icache_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int LINE_WIDTH = LINE_W,
  parameter int BEAT_WIDTH = BEAT_W,
  parameter int SET_DEPTH  = SETS
) (
  input  logic                                                          CLK,
  input  logic                                                          RESET_N,
  input  logic                                                          MISS_VALID,
  input  logic [ADDR_WIDTH-1:0]                                         MISS_ADDRESS,
  output logic                                                          MISS_READY,
  input  logic                                                          FLUSH,
  output logic                                                          MEM_REQ_VALID,
  output logic [ADDR_WIDTH-1:0]                                         MEM_REQ_ADDRESS,
  input  logic                                                          MEM_REQ_READY,
  input  logic                                                          MEM_RESP_VALID,
  input  logic [BEAT_WIDTH-1:0]                                         MEM_RESP_DATA,
  output logic                                                          MEM_RESP_READY,
  output logic [$clog2(SET_DEPTH)-1:0]                                  DATA_WRITE_ADDRESS,
  output logic [LINE_WIDTH-1:0]                                         DATA_WRITE_LINE,
  output logic                                                          DATA_WRITE_ENABLE,
  output logic [$clog2(SET_DEPTH)-1:0]                                  TAG_WRITE_ADDRESS,
  output logic [ADDR_WIDTH-$clog2(SET_DEPTH)-$clog2(LINE_WIDTH/8):0]    TAG_WRITE_DATA,
  output logic                                                          TAG_WRITE_ENABLE,
  output logic                                                          REFILL_DONE,
  output logic                                                          FLUSH_DONE,
  output logic                                                          BUSY
);

  localparam int INDEX_WIDTH  = $clog2(SET_DEPTH);
  localparam int OFFSET_WIDTH = $clog2(LINE_WIDTH / 8);
  localparam int TAG_WIDTH    = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int LINE_BEATS   = LINE_WIDTH / BEAT_WIDTH;

  localparam logic [2:0] S_IDLE          = ST_IDLE;
  localparam logic [2:0] S_REQUEST       = ST_REQUEST;
  localparam logic [2:0] S_COLLECT       = ST_COLLECT;
  localparam logic [2:0] S_WRITE         = ST_WRITE;
  localparam logic [2:0] S_DONE          = ST_DONE;
  localparam logic [2:0] S_FLUSH         = ST_FLUSH;
  localparam logic [2:0] S_FLUSH_DONE_ST = ST_FLUSH_DONE_ST;

  if (LINE_BEATS < 2 || (LINE_BEATS & (LINE_BEATS - 1)) != 0 ||
      LINE_BEATS * BEAT_WIDTH != LINE_WIDTH) begin : g_bad_beats
    $error("icache_line_refill: LINE_WIDTH/BEAT_WIDTH must be a power of two >= 2");
  end

  logic [2:0]              state;
  logic [TAG_WIDTH-1:0]    tag_q;
  logic [INDEX_WIDTH-1:0]  index_q;
  logic [INDEX_WIDTH-1:0]  set_cnt;
  logic                    miss_accept;
  logic                    beat_insert;
  logic                    beat_last;
  logic [LINE_WIDTH-1:0]   line_buf;
  logic                    unused_offset;

  assign miss_accept   = (state == S_IDLE) && !FLUSH && MISS_VALID;
  assign beat_insert   = (state == S_COLLECT) && MEM_RESP_VALID;
  assign unused_offset = ^MISS_ADDRESS[OFFSET_WIDTH-1:0];

  icache_line_assembler #(
    .LINE_WIDTH (LINE_WIDTH),
    .BEAT_WIDTH (BEAT_WIDTH)
  ) u_assembler (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .clear   (miss_accept),
    .insert  (beat_insert),
    .beat    (MEM_RESP_DATA),
    .line    (line_buf),
    .last    (beat_last)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= S_IDLE;
      tag_q   <= '0;
      index_q <= '0;
      set_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // A flush request wins over a simultaneous miss; the miss stays unaccepted.
          if (FLUSH) begin
            set_cnt <= '0;
            state   <= S_FLUSH;
          end else if (MISS_VALID) begin
            tag_q   <= MISS_ADDRESS[ADDR_WIDTH-1 -: TAG_WIDTH];
            index_q <= MISS_ADDRESS[OFFSET_WIDTH +: INDEX_WIDTH];
            state   <= S_REQUEST;
          end
        end
        S_REQUEST: begin
          if (MEM_REQ_READY) begin
            state <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (MEM_RESP_VALID && beat_last) begin
            state <= S_WRITE;
          end
        end
        S_WRITE:  state <= S_DONE;
        S_DONE:   state <= S_IDLE;
        S_FLUSH: begin
          set_cnt <= set_cnt + 1'b1;
          if (set_cnt == INDEX_WIDTH'(SET_DEPTH - 1)) begin
            state <= S_FLUSH_DONE_ST;
          end
        end
        S_FLUSH_DONE_ST: state <= S_IDLE;
        default:         state <= S_IDLE;
      endcase
    end
  end

  // All strobes decode the registered state only, so no input reaches an output combinationally.
  assign MISS_READY         = (state == S_IDLE);
  assign BUSY               = (state != S_IDLE);
  assign MEM_REQ_VALID      = (state == S_REQUEST);
  assign MEM_REQ_ADDRESS    = {tag_q, index_q, {OFFSET_WIDTH{1'b0}}};
  assign MEM_RESP_READY     = (state == S_COLLECT);
  assign DATA_WRITE_ENABLE  = (state == S_WRITE);
  assign DATA_WRITE_ADDRESS = index_q;
  assign DATA_WRITE_LINE    = line_buf;
  assign TAG_WRITE_ENABLE   = (state == S_WRITE) || (state == S_FLUSH);
  assign TAG_WRITE_ADDRESS  = (state == S_FLUSH) ? set_cnt : index_q;
  assign TAG_WRITE_DATA     = (state == S_FLUSH) ? '0 : {1'b1, tag_q};
  assign REFILL_DONE        = (state == S_DONE);
  assign FLUSH_DONE         = (state == S_FLUSH_DONE_ST);

endmodule

// File: tb/tb_icache_line_refill.sv
// tb/tb_icache_line_refill.sv - randomized self-checking bench for icache_line_refill against a line-level reference model
module tb_icache_line_refill;

  logic         CLK = 1'b0;
  logic         RESET_N = 1'b0;
  logic         MISS_VALID = 1'b0;
  logic [31:0]  MISS_ADDRESS = '0;
  logic         MISS_READY;
  logic         FLUSH = 1'b0;
  logic         MEM_REQ_VALID;
  logic [31:0]  MEM_REQ_ADDRESS;
  logic         MEM_REQ_READY = 1'b0;
  logic         MEM_RESP_VALID = 1'b0;
  logic [31:0]  MEM_RESP_DATA = '0;
  logic         MEM_RESP_READY;
  logic [8:0]   DATA_WRITE_ADDRESS;
  logic [511:0] DATA_WRITE_LINE;
  logic         DATA_WRITE_ENABLE;
  logic [8:0]   TAG_WRITE_ADDRESS;
  logic [17:0]  TAG_WRITE_DATA;
  logic         TAG_WRITE_ENABLE;
  logic         REFILL_DONE;
  logic         FLUSH_DONE;
  logic         BUSY;

  logic         m64_miss_valid = 1'b0;
  logic [31:0]  m64_miss_address = '0;
  logic         m64_miss_ready;
  logic         m64_flush = 1'b0;
  logic         m64_req_valid;
  logic [31:0]  m64_req_address;
  logic         m64_req_ready = 1'b0;
  logic         m64_resp_valid = 1'b0;
  logic [63:0]  m64_resp_data = '0;
  logic         m64_resp_ready;
  logic [8:0]   m64_data_addr;
  logic [511:0] m64_line;
  logic         m64_dwe;
  logic [8:0]   m64_tag_addr;
  logic [17:0]  m64_tag_data;
  logic         m64_twe;
  logic         m64_refill_done;
  logic         m64_flush_done;
  logic         m64_busy;

  int n_checks  = 0;
  int n_fail    = 0;
  int dwe_total = 0;

  always #5 CLK = ~CLK;

  icache_line_refill dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .MISS_VALID(MISS_VALID), .MISS_ADDRESS(MISS_ADDRESS), .MISS_READY(MISS_READY),
    .FLUSH(FLUSH),
    .MEM_REQ_VALID(MEM_REQ_VALID), .MEM_REQ_ADDRESS(MEM_REQ_ADDRESS), .MEM_REQ_READY(MEM_REQ_READY),
    .MEM_RESP_VALID(MEM_RESP_VALID), .MEM_RESP_DATA(MEM_RESP_DATA), .MEM_RESP_READY(MEM_RESP_READY),
    .DATA_WRITE_ADDRESS(DATA_WRITE_ADDRESS), .DATA_WRITE_LINE(DATA_WRITE_LINE),
    .DATA_WRITE_ENABLE(DATA_WRITE_ENABLE),
    .TAG_WRITE_ADDRESS(TAG_WRITE_ADDRESS), .TAG_WRITE_DATA(TAG_WRITE_DATA),
    .TAG_WRITE_ENABLE(TAG_WRITE_ENABLE),
    .REFILL_DONE(REFILL_DONE), .FLUSH_DONE(FLUSH_DONE), .BUSY(BUSY)
  );

  icache_line_refill #(.BEAT_WIDTH(64)) dut64 (
    .CLK(CLK), .RESET_N(RESET_N),
    .MISS_VALID(m64_miss_valid), .MISS_ADDRESS(m64_miss_address), .MISS_READY(m64_miss_ready),
    .FLUSH(m64_flush),
    .MEM_REQ_VALID(m64_req_valid), .MEM_REQ_ADDRESS(m64_req_address), .MEM_REQ_READY(m64_req_ready),
    .MEM_RESP_VALID(m64_resp_valid), .MEM_RESP_DATA(m64_resp_data), .MEM_RESP_READY(m64_resp_ready),
    .DATA_WRITE_ADDRESS(m64_data_addr), .DATA_WRITE_LINE(m64_line), .DATA_WRITE_ENABLE(m64_dwe),
    .TAG_WRITE_ADDRESS(m64_tag_addr), .TAG_WRITE_DATA(m64_tag_data), .TAG_WRITE_ENABLE(m64_twe),
    .REFILL_DONE(m64_refill_done), .FLUSH_DONE(m64_flush_done), .BUSY(m64_busy)
  );

  always @(negedge CLK) begin
    if (DATA_WRITE_ENABLE === 1'b1) dwe_total++;
  end

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One miss against a memory model that returns beat k as base+k in ascending order.
  task automatic run_miss(input string name, input logic [31:0] addr, input logic [31:0] base,
                          input int req_stall, input bit gaps, input bit stray, input int abort_after);
    logic [511:0] line_exp, line_got;
    logic [31:0]  exp_addr;
    logic [8:0]   exp_idx, idx_got, tidx_got;
    logic [17:0]  exp_tag, tdat_got;
    logic         twe_got;
    int k = 0, gap = 0, stall = 0, lat = -1, writes = 0, dwe_start;
    bit addr_bad = 0, stray_bad = 0, done = 0;
    line_got = '0; idx_got = '0; tidx_got = '0; tdat_got = '0; twe_got = 1'b0;
    for (int i = 0; i < 16; i++) line_exp[i*32 +: 32] = base + 32'(i);
    exp_addr  = addr - (addr % 64);
    exp_idx   = 9'((addr / 64) % 512);
    exp_tag   = {1'b1, 17'(addr / 32768)};
    dwe_start = dwe_total;
    @(negedge CLK);
    check({name, " miss_ready"}, MISS_READY, 1'b1);
    MISS_VALID = 1'b1;
    MISS_ADDRESS = addr;
    for (int c = 1; c < 300 && !done; c++) begin
      @(negedge CLK);
      if (abort_after > 0 && k == abort_after) begin
        RESET_N = 1'b0;
        MEM_RESP_VALID = 1'b0;
        MEM_REQ_READY = 1'b0;
        MISS_VALID = 1'b0;
        FLUSH = 1'b0;
        #1;
        check({name, " rst miss_ready"}, MISS_READY, 1'b1);
        check({name, " rst busy"}, BUSY, 1'b0);
        check({name, " rst resp_ready"}, MEM_RESP_READY, 1'b0);
        check({name, " rst strobes"}, {DATA_WRITE_ENABLE, TAG_WRITE_ENABLE, REFILL_DONE, MEM_REQ_VALID}, 4'b0);
        repeat (3) @(negedge CLK);
        RESET_N = 1'b1;
        repeat (2) @(negedge CLK);
        check({name, " no partial write"}, dwe_total - dwe_start, 0);
        return;
      end
      if (DATA_WRITE_ENABLE) begin
        writes++;
        line_got = DATA_WRITE_LINE;
        idx_got  = DATA_WRITE_ADDRESS;
        tidx_got = TAG_WRITE_ADDRESS;
        tdat_got = TAG_WRITE_DATA;
        twe_got  = TAG_WRITE_ENABLE;
      end
      if (REFILL_DONE) begin
        done = 1;
        lat = c;
      end
      if (MEM_REQ_VALID && MEM_REQ_ADDRESS !== exp_addr) addr_bad = 1;
      if (MEM_REQ_VALID && MEM_RESP_READY) stray_bad = 1;
      if (stray && MEM_RESP_READY && MISS_READY) stray_bad = 1;
      MEM_REQ_READY = MEM_REQ_VALID && (stall >= req_stall);
      if (MEM_REQ_VALID) stall++;
      if (MEM_RESP_READY && gap == 0) begin
        MEM_RESP_VALID = 1'b1;
        MEM_RESP_DATA = base + 32'(k);
        k++;
        gap = gaps ? $urandom_range(1, 3) : 0;
      end else begin
        if (MEM_RESP_READY) gap--;
        MEM_RESP_VALID = stray && MEM_REQ_VALID;
        MEM_RESP_DATA = $urandom;
      end
      MISS_VALID = stray && MEM_RESP_READY;
      FLUSH = stray && MEM_RESP_READY;
      MISS_ADDRESS = stray ? $urandom : addr;
    end
    MEM_RESP_VALID = 1'b0;
    MEM_REQ_READY = 1'b0;
    MISS_VALID = 1'b0;
    FLUSH = 1'b0;
    check({name, " refill_done seen"}, done, 1'b1);
    if (req_stall == 0 && !gaps) check({name, " latency"}, lat, 19);
    check({name, " write strobes"}, writes, 1);
    check({name, " req addr"}, addr_bad, 1'b0);
    check({name, " stray ignored"}, stray_bad, 1'b0);
    check({name, " beats consumed"}, k, 16);
    check({name, " line"}, line_got, line_exp);
    check({name, " data index"}, idx_got, exp_idx);
    check({name, " tag index"}, tidx_got, exp_idx);
    check({name, " tag data"}, tdat_got, exp_tag);
    check({name, " tag we"}, twe_got, 1'b1);
  endtask

  task automatic run_flush();
    int n = 0, last_we = -1, done_at = -1;
    bit bad = 0;
    @(negedge CLK);
    check("flush idle", MISS_READY, 1'b1);
    FLUSH = 1'b1;
    MISS_VALID = 1'b1;
    MISS_ADDRESS = 32'h1234_5678;
    for (int c = 1; c < 700 && done_at < 0; c++) begin
      @(negedge CLK);
      FLUSH = 1'b0;
      MISS_VALID = 1'b0;
      if (TAG_WRITE_ENABLE) begin
        if (TAG_WRITE_ADDRESS !== 9'(n) || TAG_WRITE_DATA !== 18'd0) bad = 1;
        if (last_we >= 0 && last_we != c - 1) bad = 1;
        n++;
        last_we = c;
      end
      if (DATA_WRITE_ENABLE || MEM_REQ_VALID || MISS_READY) bad = 1;
      if (FLUSH_DONE) done_at = c;
    end
    check("flush tag writes", n, 512);
    check("flush sequence", bad, 1'b0);
    check("flush first cycle", last_we - n + 1, 1);
    check("flush done after sweep", done_at, last_we + 1);
    @(negedge CLK);
    check("flush then ready", {MISS_READY, BUSY}, 2'b10);
  endtask

  task automatic run_miss64(input logic [31:0] addr, input logic [63:0] base);
    logic [511:0] exp_line, got;
    logic [17:0]  tg;
    int k = 0, writes = 0, lat = -1;
    got = '0;
    tg = '0;
    for (int i = 0; i < 8; i++) exp_line[i*64 +: 64] = base + 64'(i);
    @(negedge CLK);
    check("w64 ready", m64_miss_ready, 1'b1);
    m64_miss_valid = 1'b1;
    m64_miss_address = addr;
    for (int c = 1; c < 100 && lat < 0; c++) begin
      @(negedge CLK);
      if (m64_dwe) begin
        writes++;
        got = m64_line;
        tg = m64_tag_data;
      end
      if (m64_refill_done) lat = c;
      m64_miss_valid = 1'b0;
      m64_req_ready = m64_req_valid;
      m64_resp_valid = m64_resp_ready;
      if (m64_resp_ready) begin
        m64_resp_data = base + 64'(k);
        k++;
      end
    end
    m64_resp_valid = 1'b0;
    m64_req_ready = 1'b0;
    check("w64 latency", lat, 11);
    check("w64 writes", writes, 1);
    check("w64 line", got, exp_line);
    check("w64 tag data", tg, {1'b1, 17'(addr / 32768)});
  endtask

  initial begin
    RESET_N = 1'b0;
    #1;
    check("reset miss_ready", MISS_READY, 1'b1);
    check("reset busy", BUSY, 1'b0);
    check("reset req/resp", {MEM_REQ_VALID, MEM_RESP_READY}, 2'b00);
    check("reset strobes", {DATA_WRITE_ENABLE, TAG_WRITE_ENABLE, REFILL_DONE, FLUSH_DONE}, 4'b0);
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;

    run_miss("zero stall", 32'h8001_2345, 32'hA000_0000, 0, 1'b0, 1'b0, 0);
    run_miss("backpressure", 32'h8001_2345, 32'hA000_0000, 5, 1'b1, 1'b0, 0);
    run_flush();
    run_miss("stray", 32'h0ABC_DEF0, 32'h5555_0000, 2, 1'b1, 1'b1, 0);
    run_miss("abort", 32'h7FFF_FFC4, 32'h1111_0000, 0, 1'b0, 1'b0, 8);
    run_miss("after abort", 32'h7FFF_FFC4, 32'h2222_0000, 0, 1'b0, 1'b0, 0);
    for (int t = 0; t < 6; t++) begin
      run_miss($sformatf("rand%0d", t), $urandom, $urandom, $urandom_range(0, 5),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
    end
    run_miss64(32'hFFFF_FFFF, 64'hDEAD_BEEF_0000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
